// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data word width and the stack operation decode.
package cpu_pkg;

   localparam int unsigned WORD_WIDTH = 8;

   typedef enum logic [1:0] {
      STACK_NONE    = 2'b00,
      STACK_POP     = 2'b01,
      STACK_PUSH    = 2'b10,
      STACK_REPLACE = 2'b11
   } stack_op_e;

   // Operation is encoded directly as {push, pop}.
   function automatic stack_op_e decode_op(input logic push, input logic pop);
      return stack_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/stack_unit_if.sv
// Control-unit / data-bus side of the stack: strobes and push data in, status and top-of-stack out.
interface stack_unit_if
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = 16
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] datain;
   logic             clearerr;
   logic [WIDTH-1:0] top;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, pop, datain, clearerr,
      input  top, count, empty, full, overflow, underflow
   );

   modport slave (
      input  push, pop, datain, clearerr,
      output top, count, empty, full, overflow, underflow
   );

endinterface

// File: rtl/stack_pointer.sv
// Saturating up/down stack pointer with registered full/empty status.
module stack_pointer #(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   input  logic          dec_i,
   output logic [CW-1:0] count_o,
   output logic          empty_o,
   output logic          full_o
);

   logic [CW-1:0] count_q, count_d;
   logic          empty_q, full_q;

   always_comb begin
      count_d = count_q;
      if (inc_i && !dec_i && (count_q != CW'(DEPTH))) begin
         count_d = count_q + CW'(1);
      end else if (dec_i && !inc_i && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   // Status flags are registered alongside the count so they track it exactly.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         empty_q <= (count_d == '0);
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   assign count_o = count_q;
   assign empty_o = empty_q;
   assign full_o  = full_q;

endmodule

// File: rtl/stack_unit.sv
// Hardware LIFO for return addresses and data words, with sticky overflow/underflow flags.
module stack_unit
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_WIDTH,
   parameter int unsigned DEPTH = 16
) (
   input logic         clock,
   input logic         reset,
   stack_unit_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] top_q, top_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             ptr_inc, ptr_dec;
   logic             wr_en;
   logic [AW-1:0]    wr_idx;
   logic [CW-1:0]    count;
   logic             empty, full;
   stack_op_e        op;

   assign op = decode_op(bus.push, bus.pop);

   stack_pointer #(.DEPTH(DEPTH)) u_ptr (
      .clk_i   (clock),
      .rst_ni  (reset),
      .inc_i   (ptr_inc),
      .dec_i   (ptr_dec),
      .count_o (count),
      .empty_o (empty),
      .full_o  (full)
   );

   // Operation decode: accept or reject, pick the write slot and next top word.
   always_comb begin
      top_d   = top_q;
      ovf_d   = ovf_q & ~bus.clearerr;
      udf_d   = udf_q & ~bus.clearerr;
      ptr_inc = 1'b0;
      ptr_dec = 1'b0;
      wr_en   = 1'b0;
      wr_idx  = AW'(count);
      case (op)
         STACK_PUSH: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               ptr_inc = 1'b1;
               wr_en   = 1'b1;
               top_d   = bus.datain;
            end
         end
         STACK_POP: begin
            if (empty) begin
               udf_d = 1'b1;
            end else begin
               ptr_dec = 1'b1;
               top_d   = (count == CW'(1)) ? '0 : mem[AW'(count - CW'(2))];
            end
         end
         STACK_REPLACE: begin
            // On an empty stack this degenerates to a push into slot 0.
            wr_en = 1'b1;
            top_d = bus.datain;
            if (empty) begin
               ptr_inc = 1'b1;
            end else begin
               wr_idx = AW'(count - CW'(1));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         top_q <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         top_q <= top_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   // Storage contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clock) begin
      if (reset && wr_en) begin
         mem[wr_idx] <= bus.datain;
      end
   end

   assign bus.top       = top_q;
   assign bus.count     = count;
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = udf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit: directed scenarios then random traffic against a queue-based model.
module tb_stack_unit;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;

   typedef struct {
      logic [WIDTH-1:0] top;
      int               count;
      bit               empty;
      bit               full;
      bit               ovf;
      bit               udf;
   } exp_t;

   logic clk;
   logic reset;

   stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bit [WIDTH-1:0] stk [$];
   bit             m_ovf;
   bit             m_udf;
   exp_t           exp_q [$];
   int             vectors;
   int             miscompares;

   // Apply one cycle of inputs and record what the stack must look like after that edge.
   task automatic step(input bit p, input bit q, input bit [WIDTH-1:0] d,
                       input bit clr, input bit rn);
      exp_t e;
      bit   set_o, set_u;
      @(negedge clk);
      bus.push     = p;
      bus.pop      = q;
      bus.datain   = d;
      bus.clearerr = clr;
      reset        = rn;
      if (!rn) begin
         stk.delete();
         m_ovf = 0;
         m_udf = 0;
      end else begin
         set_o = 0;
         set_u = 0;
         if (p && !q) begin
            if (stk.size() == DEPTH) set_o = 1;
            else stk.push_back(d);
         end else if (q && !p) begin
            if (stk.size() == 0) set_u = 1;
            else void'(stk.pop_back());
         end else if (p && q) begin
            if (stk.size() == 0) stk.push_back(d);
            else stk[stk.size()-1] = d;
         end
         m_ovf = set_o | (m_ovf & !clr);
         m_udf = set_u | (m_udf & !clr);
      end
      e.count = stk.size();
      e.top   = (stk.size() == 0) ? '0 : stk[stk.size()-1];
      e.empty = (stk.size() == 0);
      e.full  = (stk.size() == DEPTH);
      e.ovf   = m_ovf;
      e.udf   = m_udf;
      exp_q.push_back(e);
   endtask

   // Monitor: every edge with an outstanding expectation is checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (bus.top !== e.top || int'(bus.count) !== e.count ||
                bus.empty !== e.empty || bus.full !== e.full ||
                bus.overflow !== e.ovf || bus.underflow !== e.udf) begin
               miscompares++;
               $display("FAIL stack_state vec %0d: got top=%h count=%0d empty=%b full=%b ovf=%b udf=%b, need top=%h count=%0d empty=%b full=%b ovf=%b udf=%b",
                        vectors, bus.top, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow,
                        e.top, e.count, e.empty, e.full, e.ovf, e.udf);
            end
         end
      end
   end

   initial begin
      bit p, q;
      bus.push     = 1'b0;
      bus.pop      = 1'b0;
      bus.datain   = '0;
      bus.clearerr = 1'b0;
      reset        = 1'b0;

      // Reset then idle
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 0, 1);

      // Fill and drain
      for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 0, 1);
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 1);

      // Overflow, sticky across a pop, then cleared
      for (int i = 0; i < 16; i++) step(1, 0, 8'(8'h10 + i), 0, 1);
      step(1, 0, 8'hAA, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      step(0, 0, 8'h00, 1, 1);
      step(1, 0, 8'hBB, 1, 1);
      step(1, 0, 8'hCC, 1, 1);

      // Underflow; an error in the same cycle as clearerr wins
      for (int i = 0; i < 16; i++) step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h00, 1, 1);
      step(0, 0, 8'h00, 1, 1);

      // Replace, and replace on empty behaving as push
      step(1, 0, 8'h05, 0, 1);
      step(1, 0, 8'h06, 0, 1);
      step(1, 1, 8'h77, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      step(0, 1, 8'h00, 0, 1);
      step(1, 1, 8'h33, 0, 1);
      step(0, 1, 8'h00, 0, 1);

      // Reset mid-operation
      step(1, 0, 8'h01, 0, 1);
      step(1, 0, 8'h02, 0, 1);
      step(1, 0, 8'h03, 0, 1);
      step(1, 0, 8'h04, 0, 0);
      step(1, 0, 8'h09, 0, 1);

      // Random traffic, biased in phases so both full and empty are reached
      for (int i = 0; i < 800; i++) begin
         int pct;
         pct = ((i / 100) % 2 == 0) ? 70 : 30;
         p = ($urandom_range(99) < pct);
         q = ($urandom_range(99) < (100 - pct));
         step(p, q, 8'($urandom), ($urandom_range(99) < 8), ($urandom_range(99) >= 1));
      end

      step(0, 0, 8'h00, 0, 1);
      for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d outstanding expectations, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO stack for the 8-bit CPU: holds return addresses and pushed data words. It is the consumer side of the up/down pointer scheme. Push grows the stack and pop shrinks it, with full/empty status and sticky overflow/underflow errors. It sits between the control unit, which issues push/pop strobes, and the data bus, which carries push data and takes the top-of-stack word.

## Interface
Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of entries; power of two, at least 2.

Ports:
- clock  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
- push  input  1  write datain onto the stack this cycle.
- pop  input  1  remove the top entry this cycle.
- datain  input  WIDTH  word to push.
- clearerr  input  1  clear the sticky error flags.
- top  output  WIDTH  current top-of-stack word; 0 when empty.
- count  output  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: a push was rejected.
- underflow  output  1  sticky: a pop was rejected.

## Operation
- Reset (reset low at an edge): count=0, top=0, empty=1, full=0, overflow=0, underflow=0. Storage contents are don't-care. Reset overrides every other input.
- The operation is decoded from {push,pop}:
  - NONE (00): hold all state.
  - PUSH (10):
    - Not full: store datain at index count, count+1, top=datain.
    - Full: no state change, overflow set.
  - POP (01):
    - Not empty: count-1, top=entry[count-2], or 0 if the stack becomes empty.
    - Empty: no state change, underflow set.
  - REPLACE (11):
    - Not empty: overwrite entry[count-1] with datain, count unchanged, top=datain.
    - Empty: behaves as PUSH. Neither error flag sets.
- Stack pointer arithmetic: count is the pointer, never wraps, and saturates at 0 and DEPTH only by rejecting the operation.
- clearerr clears overflow/underflow at the edge. If an error occurs in the same cycle, the error wins and the flag stays/becomes 1.
- Error flags do not block later operations.

## Timing
- All outputs are registered, or decoded purely from registered count. Nothing is combinational from inputs to outputs.
- Latency is 1 cycle. The edge sampling push/pop updates top, count, empty and full, visible immediately after that edge.
- Back-to-back operations are allowed every cycle. There are no stall cycles and no ready signal.
- A pop immediately following a push returns the pushed word's predecessor on top after the pop edge.
- Reset asserted mid-sequence discards the whole stack at that edge. The first operation after reset is deasserted sees an empty stack.

## Structure
- Shared package cpu_pkg:
  - WORD_WIDTH constant (8).
  - Enum stack_op_e {STACK_NONE, STACK_PUSH, STACK_POP, STACK_REPLACE} built from {push,pop}.
- Sub-module stack_pointer: up/down register of width $clog2(DEPTH)+1 with synchronous active-low reset, inc/dec enables, and full/empty decode. stack_unit instantiates it once and owns the storage array and the top register.
- Storage is a register array of DEPTH x WIDTH, written only on accepted PUSH/REPLACE.

## Test plan
- Reset then idle: hold reset low for 2 cycles, release -> count=0, empty=1, full=0, top=0, both error flags 0.
- Fill and drain: push 0x10..0x1F (16 pushes) -> full=1, count=16, top=0x1F. Then 16 pops -> top sequence 0x1E..0x10 then 0, empty=1, no errors.
- Overflow: while full, push 0xAA -> count stays 16, top stays 0x1F, overflow=1. Pop -> top=0x1E, overflow stays 1. clearerr -> overflow=0.
- Underflow: pop on empty -> count=0, top=0, underflow=1. Same-cycle pop-on-empty with clearerr -> underflow remains 1.
- Replace: push 0x05, push 0x06, then push+pop with datain 0x77 -> count=2, top=0x77. Pop -> top=0x05. Push+pop on empty with 0x33 -> count=1, top=0x33, no errors.
- Reset mid-operation: push 0x01,0x02,0x03, assert reset concurrently with a push of 0x04 -> count=0, top=0, empty=1. After release, push 0x09 -> count=1, top=0x09.
